// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector over raster-order greyscale frames.
// Two line buffers supply the upper rows of the window. A single output
// register carries one result per interior pixel, tagged with its linear
// address. Backpressure on the output stalls the input.
module sobel_stream #(
  parameter int unsigned IMG_W  = 64,
  parameter int unsigned IMG_H  = 64,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned MODE   = 0,
  parameter int unsigned THRESH = 128,
  localparam int unsigned AW    = $clog2(IMG_W * IMG_H)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pix,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pix,
  output logic [AW-1:0]    out_addr,
  output logic             frame_done
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam int unsigned GW = PIX_W + 3;
  localparam int unsigned MW = PIX_W + 4;
  localparam int unsigned MaxPix = (2 ** PIX_W) - 1;
  localparam logic [AW-1:0] LastAddr = AW'((IMG_H - 2) * IMG_W + IMG_W - 2);

  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [PIX_W-1:0] win_q [3][3];
  logic [PIX_W-1:0] win_d [3][3];
  logic             out_valid_q, out_valid_d;
  logic [PIX_W-1:0] out_pix_q, out_pix_d;
  logic [AW-1:0]    out_addr_q, out_addr_d;

  logic [PIX_W-1:0] lb0_mem [IMG_W];
  logic [PIX_W-1:0] lb1_mem [IMG_W];
  logic [PIX_W-1:0] lb0_rd, lb1_rd;

  logic             accept;
  logic [GW-1:0]    gx, gy, abs_x, abs_y;
  logic [MW-1:0]    mag;
  logic [PIX_W-1:0] result;

  function automatic logic [GW-1:0] ext(input logic [PIX_W-1:0] p);
    return GW'(p);
  endfunction

  // The single output register must be free (or draining) before a new pixel enters.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign lb0_rd   = lb0_mem[col_q];
  assign lb1_rd   = lb1_mem[col_q];

  // Raster counters and window shift on each accepted pixel.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb1_rd;
      win_d[1][2] = lb0_rd;
      win_d[2][2] = in_pix;
      if (col_q == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Gradient and result computed from the window as it will be after this accept.
  always_comb begin
    gx = (ext(win_d[0][2]) + (ext(win_d[1][2]) << 1) + ext(win_d[2][2]))
       - (ext(win_d[0][0]) + (ext(win_d[1][0]) << 1) + ext(win_d[2][0]));
    gy = (ext(win_d[2][0]) + (ext(win_d[2][1]) << 1) + ext(win_d[2][2]))
       - (ext(win_d[0][0]) + (ext(win_d[0][1]) << 1) + ext(win_d[0][2]));
    abs_x = gx[GW-1] ? -gx : gx;
    abs_y = gy[GW-1] ? -gy : gy;
    mag   = MW'(abs_x) + MW'(abs_y);
    if (MODE == 0) begin
      result = (mag > MW'(MaxPix)) ? '1 : mag[PIX_W-1:0];
    end else begin
      result = (32'(mag) >= THRESH) ? '1 : '0;
    end
  end

  // Output register: reloads on an interior accept, otherwise drains on out_ready.
  always_comb begin
    out_valid_d = out_valid_q;
    out_pix_d   = out_pix_q;
    out_addr_d  = out_addr_q;
    if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (accept && row_q >= RW'(2) && col_q >= CW'(2)) begin
      out_valid_d = 1'b1;
      out_pix_d   = result;
      out_addr_d  = AW'(row_q - RW'(1)) * AW'(IMG_W) + AW'(col_q - CW'(1));
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_pix_q   <= '0;
      out_addr_q  <= '0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_pix_q   <= out_pix_d;
      out_addr_q  <= out_addr_d;
      win_q       <= win_d;
    end
  end

  // Line buffers: rows 0 and 1 of each frame overwrite stale contents before any output.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_mem[col_q] <= lb0_rd;
      lb0_mem[col_q] <= in_pix;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_pix    = out_pix_q;
  assign out_addr   = out_addr_q;
  assign frame_done = out_valid_q && (out_addr_q == LastAddr);

endmodule

// File: tb/tb_sobel_stream.sv
// Bench for sobel_stream: three 4x4 instances (saturating, threshold 50, threshold 90)
// sharing one stimulus stream, plus one 64x64 saturating instance. A frame-image model
// computes every expected beat directly from the Sobel definition.
module tb_sobel_stream;

  typedef struct {
    int mag;
    int addr;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_valid, a_ready_out;
  logic [7:0] a_pix;
  logic [2:0] a_irdy, a_ov, a_fd;
  logic [7:0] a_op [3];
  logic [3:0] a_oa [3];

  logic        b_valid, b_ready_out, b_irdy, b_ov, b_fd;
  logic [7:0]  b_pix, b_op;
  logic [11:0] b_oa;

  int   tests = 0;
  int   fails = 0;
  int   img_a [16];
  int   img_b [4096];
  int   cnt_a = 0;
  int   cnt_b = 0;
  int   beats_a = 0;
  int   beats_b = 0;
  exp_t qa [$];
  exp_t qb [$];
  int   pin = 0;
  bit   rnd_ready = 0;
  int   lit_addr [4] = '{5, 6, 9, 10};

  sobel_stream #(.IMG_W(4), .IMG_H(4), .PIX_W(8), .MODE(0), .THRESH(128)) u_a0 (
    .clk(clk), .reset(rst), .in_valid(a_valid), .in_ready(a_irdy[0]), .in_pix(a_pix),
    .out_valid(a_ov[0]), .out_ready(a_ready_out), .out_pix(a_op[0]), .out_addr(a_oa[0]),
    .frame_done(a_fd[0]));
  sobel_stream #(.IMG_W(4), .IMG_H(4), .PIX_W(8), .MODE(1), .THRESH(50)) u_a1 (
    .clk(clk), .reset(rst), .in_valid(a_valid), .in_ready(a_irdy[1]), .in_pix(a_pix),
    .out_valid(a_ov[1]), .out_ready(a_ready_out), .out_pix(a_op[1]), .out_addr(a_oa[1]),
    .frame_done(a_fd[1]));
  sobel_stream #(.IMG_W(4), .IMG_H(4), .PIX_W(8), .MODE(1), .THRESH(90)) u_a2 (
    .clk(clk), .reset(rst), .in_valid(a_valid), .in_ready(a_irdy[2]), .in_pix(a_pix),
    .out_valid(a_ov[2]), .out_ready(a_ready_out), .out_pix(a_op[2]), .out_addr(a_oa[2]),
    .frame_done(a_fd[2]));
  sobel_stream u_b (
    .clk(clk), .reset(rst), .in_valid(b_valid), .in_ready(b_irdy), .in_pix(b_pix),
    .out_valid(b_ov), .out_ready(b_ready_out), .out_pix(b_op), .out_addr(b_oa),
    .frame_done(b_fd));

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int px(input bit g, input int r, input int c);
    return g ? img_b[r * 64 + c] : img_a[r * 4 + c];
  endfunction

  // |Gx|+|Gy| for centre (r,c), straight from the image.
  function automatic int sobel_mag(input bit g, input int r, input int c);
    int gx, gy;
    gx = (px(g, r-1, c+1) + 2 * px(g, r, c+1) + px(g, r+1, c+1))
       - (px(g, r-1, c-1) + 2 * px(g, r, c-1) + px(g, r+1, c-1));
    gy = (px(g, r+1, c-1) + 2 * px(g, r+1, c) + px(g, r+1, c+1))
       - (px(g, r-1, c-1) + 2 * px(g, r-1, c) + px(g, r-1, c+1));
    return (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
  endfunction

  // Expected pixel for instance k (3 = the 64x64 one).
  function automatic int dut_pix(input int k, input int mag);
    case (k)
      1:       return (mag >= 50) ? 255 : 0;
      2:       return (mag >= 90) ? 255 : 0;
      default: return (mag > 255) ? 255 : mag;
    endcase
  endfunction

  // Compare and model process for the 4x4 group.
  always @(negedge clk) begin
    int r, c;
    exp_t e;
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        check("a_rst_out_valid", a_ov[k], 0);
        check("a_rst_frame_done", a_fd[k], 0);
        check("a_rst_in_ready", a_irdy[k], 1);
      end
      qa.delete();
      cnt_a = 0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        check("a_in_ready", a_irdy[k], int'(!a_ov[k] || a_ready_out));
        if (a_ov[k]) begin
          check("a_beat_expected", int'(qa.size() > 0), 1);
          if (qa.size() > 0) begin
            check("a_out_pix", a_op[k], dut_pix(k, qa[0].mag));
            check("a_out_addr", a_oa[k], qa[0].addr);
            check("a_frame_done", a_fd[k], int'(qa[0].addr == 10));
          end
        end else begin
          check("a_frame_done_idle", a_fd[k], 0);
        end
      end
      if (a_ov[0] && a_ready_out && qa.size() > 0) begin
        void'(qa.pop_front());
        beats_a++;
      end
      if (a_valid && a_irdy[0]) begin
        r = cnt_a / 4;
        c = cnt_a % 4;
        img_a[cnt_a] = a_pix;
        if (r >= 2 && c >= 2) begin
          e.mag  = sobel_mag(0, r - 1, c - 1);
          e.addr = (r - 1) * 4 + c - 1;
          if (pin == 1) check("pin_const_mag", e.mag, 0);
          if (pin == 2) begin
            check("pin_ramp_mag", e.mag, 80);
            check("pin_ramp_addr", e.addr, lit_addr[(r - 2) * 2 + (c - 2)]);
          end
          qa.push_back(e);
        end
        cnt_a = (cnt_a + 1) % 16;
      end
    end
  end

  // Compare and model process for the 64x64 instance.
  always @(negedge clk) begin
    int r, c;
    exp_t e;
    if (rst) begin
      check("b_rst_out_valid", b_ov, 0);
      check("b_rst_in_ready", b_irdy, 1);
      qb.delete();
      cnt_b = 0;
    end else begin
      check("b_in_ready", b_irdy, int'(!b_ov || b_ready_out));
      if (b_ov) begin
        check("b_beat_expected", int'(qb.size() > 0), 1);
        if (qb.size() > 0) begin
          check("b_out_pix", b_op, dut_pix(3, qb[0].mag));
          check("b_out_addr", b_oa, qb[0].addr);
          check("b_frame_done", b_fd, int'(qb[0].addr == 62 * 64 + 62));
        end
      end else begin
        check("b_frame_done_idle", b_fd, 0);
      end
      if (b_ov && b_ready_out && qb.size() > 0) begin
        void'(qb.pop_front());
        beats_b++;
      end
      if (b_valid && b_irdy) begin
        r = cnt_b / 64;
        c = cnt_b % 64;
        img_b[cnt_b] = b_pix;
        if (r >= 2 && c >= 2) begin
          e.mag  = sobel_mag(1, r - 1, c - 1);
          e.addr = (r - 1) * 64 + c - 1;
          if (pin == 3) begin
            check("pin_step_pix", dut_pix(3, e.mag), (c - 1 == 31 || c - 1 == 32) ? 255 : 0);
          end
          qb.push_back(e);
        end
        cnt_b = (cnt_b + 1) % 4096;
      end
    end
  end

  // Output-side ready: constant 1 or a fair coin each cycle.
  initial begin
    a_ready_out = 1'b1;
    b_ready_out = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      a_ready_out = rnd_ready ? 1'($urandom_range(1)) : 1'b1;
      b_ready_out = rnd_ready ? 1'($urandom_range(1)) : 1'b1;
    end
  end

  // kind: 0 constant 77, 1 ramp 10*col, 2 step at col 32, 3 random.
  task automatic feed(input bit g, input int kind, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      int w, p, guard;
      bit acc;
      w = g ? 64 : 4;
      case (kind)
        0:       p = 77;
        1:       p = 10 * (i % w);
        2:       p = ((i % w) < 32) ? 0 : 200;
        default: p = int'($urandom_range(255));
      endcase
      while (gap > 0 && int'($urandom_range(99)) < gap) begin
        if (g) b_valid = 1'b0; else a_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      if (g) begin
        b_valid = 1'b1;
        b_pix   = 8'(p);
      end else begin
        a_valid = 1'b1;
        a_pix   = 8'(p);
      end
      guard = 0;
      do begin
        @(negedge clk);
        acc = g ? b_irdy : a_irdy[0];
        @(posedge clk);
        #1;
        guard++;
      end while (!acc && guard < 1000);
      check("feed_accept", int'(acc), 1);
    end
    if (g) b_valid = 1'b0; else a_valid = 1'b0;
  endtask

  task automatic drain(input bit g);
    int guard;
    guard = 0;
    while ((g ? (qb.size() != 0 || b_ov) : (qa.size() != 0 || a_ov[0])) && guard < 500) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("drain_done", int'(guard < 500), 1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    rst = 1'b1;
    a_valid = 1'b0;
    a_pix = '0;
    b_valid = 1'b0;
    b_pix = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_a_out_pix", a_op[k], 0);
      check("rst_a_out_addr", a_oa[k], 0);
    end
    check("rst_b_out_pix", b_op, 0);
    check("rst_b_out_addr", b_oa, 0);
    rst = 1'b0;

    // Constant frame: all-zero gradients.
    pin = 1;
    b0 = beats_a;
    feed(0, 0, 16, 0);
    drain(0);
    check("t1_beats", beats_a - b0, 4);

    // Horizontal ramp: Gx=80, covers both thresholds.
    pin = 2;
    b0 = beats_a;
    feed(0, 1, 16, 0);
    drain(0);
    check("t2_beats", beats_a - b0, 4);

    // Same ramp with random backpressure and input gaps.
    rnd_ready = 1;
    b0 = beats_a;
    feed(0, 1, 16, 40);
    drain(0);
    check("t5_beats", beats_a - b0, 4);
    rnd_ready = 0;

    // Reset part-way into row 2, then two back-to-back ramp frames.
    pin = 0;
    feed(0, 1, 10, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    pin = 2;
    b0 = beats_a;
    feed(0, 1, 16, 0);
    feed(0, 1, 16, 0);
    drain(0);
    check("t6_beats", beats_a - b0, 8);

    // Random frames with backpressure, then a reset with output traffic in flight.
    pin = 0;
    rnd_ready = 1;
    b0 = beats_a;
    feed(0, 3, 48, 30);
    drain(0);
    check("rand_a_beats", beats_a - b0, 12);
    feed(0, 3, 12, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    b0 = beats_a;
    feed(0, 3, 16, 20);
    drain(0);
    check("rand_a_after_rst_beats", beats_a - b0, 4);

    // 64x64 step edge at full rate, then a random frame under backpressure.
    rnd_ready = 0;
    pin = 3;
    b0 = beats_b;
    feed(1, 2, 4096, 0);
    drain(1);
    check("t3_beats", beats_b - b0, 3844);
    pin = 0;
    rnd_ready = 1;
    b0 = beats_b;
    feed(1, 3, 4096, 20);
    drain(1);
    check("rand_b_beats", beats_b - b0, 3844);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
